// File: rtl/udp_cmd_pkg.sv
// udp_cmd_pkg: shared defaults and state type for the MIB bus master.
// Optional feature macro used by mib_master: MIB_MASTER_TBIT_EN.
package udp_cmd_pkg;

    localparam int MIB_ADDR_BITS               = 24;
    localparam int CMD_DATA_BITS               = 32;
    localparam int CMD_MASTER_ACK_TIMEOUT_CLKS = 256;
    localparam int MIB_TBIT_CLKS               = 4096;

    typedef enum logic [3:0] {
        ST_TRAIN,
        ST_IDLE,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_WR_HI,
        ST_WR_LO,
        ST_WAIT_ACK,
        ST_RD_LO,
        ST_DONE
    } mib_master_state_t;

endpackage

// File: rtl/mib_master_tbit_gen.sv
// mib_master_tbit_gen: deskew toggle-bit generator for post-reset training.
// Toggles every cycle for TBIT_CLKS cycles, then holds 0 and flags done.
module mib_master_tbit_gen
    import udp_cmd_pkg::*;
#(
    parameter int TBIT_CLKS = MIB_TBIT_CLKS
) (
    input  logic i_sysclk,
    input  logic i_srst,
    output logic o_tbit,
    output logic o_done
);

    localparam int CW = $clog2(TBIT_CLKS + 1);

    logic [CW-1:0] cnt_q;
    logic          tbit_q;
    logic          done_q;

    // Count training cycles and toggle the bit until the count expires.
    always_ff @(posedge i_sysclk) begin
        if (i_srst) begin
            cnt_q  <= '0;
            tbit_q <= 1'b0;
            done_q <= 1'b0;
        end else if (!done_q) begin
            tbit_q <= ~tbit_q;
            cnt_q  <= cnt_q + 1'b1;
            if (cnt_q == CW'(TBIT_CLKS - 1)) begin
                done_q <= 1'b1;
            end
        end else begin
            tbit_q <= 1'b0;
        end
    end

    assign o_tbit = tbit_q;
    assign o_done = done_q;

endmodule

// File: rtl/mib_master.sv
// mib_master: serialises one register command into MIB beats and awaits ack.
// Optional deskew training enabled by defining MIB_MASTER_TBIT_EN.
module mib_master
    import udp_cmd_pkg::*;
#(
    parameter int ADDR_BITS        = MIB_ADDR_BITS,
    parameter int DATA_BITS        = CMD_DATA_BITS,
    parameter int ACK_TIMEOUT_CLKS = CMD_MASTER_ACK_TIMEOUT_CLKS,
    parameter int TBIT_CLKS        = MIB_TBIT_CLKS
) (
    input  logic                 i_sysclk,
    input  logic                 i_srst,
    input  logic                 i_cmd_sel,
    input  logic                 i_cmd_rd_wr_n,
    input  logic [ADDR_BITS-1:0] i_cmd_addr,
    input  logic [DATA_BITS-1:0] i_cmd_wdata,
    output logic                 o_cmd_ack,
    output logic [DATA_BITS-1:0] o_cmd_rdata,
    output logic                 o_cmd_err,
    output logic                 o_mib_start,
    output logic                 o_mib_rd_wr_n,
    output logic [15:0]          o_mib_ad,
    output logic                 o_mib_ad_oe,
    input  logic [15:0]          i_mib_ad,
    input  logic                 i_mib_slave_ack,
    output logic                 o_mib_tbit,
    output logic                 o_ready
);

    localparam int TW = $clog2(ACK_TIMEOUT_CLKS + 1);

    mib_master_state_t    state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [DATA_BITS-1:0] wdata_q, wdata_d;
    logic                 rd_q, rd_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic [DATA_BITS-1:0] rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic                 cack_q, cack_d;
    logic                 start_q, start_d;
    logic                 oe_q, oe_d;
    logic [15:0]          ad_q, ad_d;
    logic                 rdwr_q, rdwr_d;
    logic                 ready_q, ready_d;
    logic [15:0]          mad_q;
    logic                 sack_q;
    logic                 tbit;
    logic                 train_done;

`ifdef MIB_MASTER_TBIT_EN
    localparam mib_master_state_t RST_STATE = ST_TRAIN;

    mib_master_tbit_gen #(
        .TBIT_CLKS (TBIT_CLKS)
    ) u_tbit (
        .i_sysclk (i_sysclk),
        .i_srst   (i_srst),
        .o_tbit   (tbit),
        .o_done   (train_done)
    );
`else
    localparam mib_master_state_t RST_STATE = ST_IDLE;

    // Without training the toggle bit is idle and training is always done.
    assign tbit       = 1'b0;
    assign train_done = (TBIT_CLKS >= 0);
`endif

    // Next-state, latching and registered-output decode.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        tmo_d   = tmo_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        unique case (state_q)
            ST_TRAIN: begin
                if (train_done) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (i_cmd_sel) begin
                    state_d = ST_ADDR_HI;
                    addr_d  = i_cmd_addr;
                    wdata_d = i_cmd_wdata;
                    rd_d    = i_cmd_rd_wr_n;
                    rdata_d = '0;
                end
            end
            ST_ADDR_HI: state_d = ST_ADDR_LO;
            ST_ADDR_LO: begin
                tmo_d   = '0;
                state_d = rd_q ? ST_WAIT_ACK : ST_WR_HI;
            end
            ST_WR_HI: state_d = ST_WR_LO;
            ST_WR_LO: begin
                tmo_d   = '0;
                state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (sack_q) begin
                    if (rd_q) begin
                        rdata_d[DATA_BITS-1:16] = mad_q;
                        state_d = ST_RD_LO;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else if (tmo_q == TW'(ACK_TIMEOUT_CLKS)) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = ST_DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_RD_LO: begin
                rdata_d[15:0] = mad_q;
                state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        start_d = 1'b0;
        oe_d    = 1'b0;
        ad_d    = '0;
        rdwr_d  = 1'b1;
        cack_d  = 1'b0;
        ready_d = 1'b0;
        case (state_d)
            ST_IDLE: ready_d = 1'b1;
            ST_ADDR_HI: begin
                start_d = 1'b1;
                oe_d    = 1'b1;
                ad_d    = 16'(addr_d[ADDR_BITS-1:16]);
                rdwr_d  = rd_d;
            end
            ST_ADDR_LO: begin
                oe_d   = 1'b1;
                ad_d   = addr_d[15:0];
                rdwr_d = rd_d;
            end
            ST_WR_HI: begin
                oe_d   = 1'b1;
                ad_d   = wdata_d[DATA_BITS-1:16];
                rdwr_d = rd_d;
            end
            ST_WR_LO: begin
                oe_d   = 1'b1;
                ad_d   = wdata_d[15:0];
                rdwr_d = rd_d;
            end
            ST_WAIT_ACK, ST_RD_LO: rdwr_d = rd_d;
            ST_DONE: begin
                cack_d = 1'b1;
                rdwr_d = rd_d;
            end
            default: ;
        endcase
    end

    // State, command latch, registered outputs and input pad registers.
    always_ff @(posedge i_sysclk) begin
        if (i_srst) begin
            state_q <= RST_STATE;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b1;
            tmo_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cack_q  <= 1'b0;
            start_q <= 1'b0;
            oe_q    <= 1'b0;
            ad_q    <= '0;
            rdwr_q  <= 1'b1;
            ready_q <= 1'b0;
            mad_q   <= '0;
            sack_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            tmo_q   <= tmo_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cack_q  <= cack_d;
            start_q <= start_d;
            oe_q    <= oe_d;
            ad_q    <= ad_d;
            rdwr_q  <= rdwr_d;
            ready_q <= ready_d;
            mad_q   <= i_mib_ad;
            sack_q  <= i_mib_slave_ack;
        end
    end

    assign o_cmd_ack     = cack_q;
    assign o_cmd_rdata   = rdata_q;
    assign o_cmd_err     = err_q;
    assign o_mib_start   = start_q;
    assign o_mib_rd_wr_n = rdwr_q;
    assign o_mib_ad      = ad_q;
    assign o_mib_ad_oe   = oe_q;
    assign o_mib_tbit    = tbit;
    assign o_ready       = ready_q;

endmodule

// File: tb/tb_mib_master.sv
// tb_mib_master: table-driven and randomized checks of mib_master.
// Optional training checks compiled when MIB_MASTER_TBIT_EN is defined.
module tb_mib_master;

    localparam int T    = 256;
    localparam int TB   = 16;
    localparam int BUDG = 400;

    logic        clk = 1'b0;
    logic        srst;
    logic        sel;
    logic        rdwr;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [15:0] ad_in;
    logic        ack_in;
    logic        cmd_ack;
    logic [31:0] cmd_rdata;
    logic        cmd_err;
    logic        mstart;
    logic        mrdwr;
    logic [15:0] mad;
    logic        moe;
    logic        tbit;
    logic        ready;

    int n_tests = 0;
    int n_fail  = 0;

    mib_master #(
        .ADDR_BITS        (24),
        .DATA_BITS        (32),
        .ACK_TIMEOUT_CLKS (T),
        .TBIT_CLKS        (TB)
    ) dut (
        .i_sysclk        (clk),
        .i_srst          (srst),
        .i_cmd_sel       (sel),
        .i_cmd_rd_wr_n   (rdwr),
        .i_cmd_addr      (addr),
        .i_cmd_wdata     (wdata),
        .o_cmd_ack       (cmd_ack),
        .o_cmd_rdata     (cmd_rdata),
        .o_cmd_err       (cmd_err),
        .o_mib_start     (mstart),
        .o_mib_rd_wr_n   (mrdwr),
        .o_mib_ad        (mad),
        .o_mib_ad_oe     (moe),
        .i_mib_ad        (ad_in),
        .i_mib_slave_ack (ack_in),
        .o_mib_tbit      (tbit),
        .o_ready         (ready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          rd;
        logic [23:0] a;
        logic [31:0] wd;
        int          d;
        logic [15:0] hi;
        logic [15:0] lo;
        int          lat;
        bit          err;
        logic [31:0] rdat;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_rst(input string nm);
        chk({nm, "_ack"}, cmd_ack, 0);
        chk({nm, "_rdata"}, cmd_rdata, 0);
        chk({nm, "_err"}, cmd_err, 0);
        chk({nm, "_start"}, mstart, 0);
        chk({nm, "_rdwr"}, mrdwr, 1);
        chk({nm, "_ad"}, mad, 0);
        chk({nm, "_oe"}, moe, 0);
        chk({nm, "_tbit"}, tbit, 0);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 100 && !ready; i++) @(negedge clk);
        chk("wait_ready", ready, 1);
    endtask

    // Reference: first WAIT_ACK cycle after sel is 3 (read) or 5 (write).
    // Raw ack d cycles in is seen one cycle later; it beats expiry while
    // that is no later than T cycles in. Timeout acks T+1 after entry.
    function automatic int model_lat(bit rd, int d);
        int w;
        w = rd ? 3 : 5;
        if (d >= 0 && d <= T - 1) return w + d + (rd ? 3 : 2);
        return w + T + 1;
    endfunction

    function automatic bit model_err(int d);
        return !(d >= 0 && d <= T - 1);
    endfunction

    task automatic run_txn(input bit rd, input logic [23:0] a,
                           input logic [31:0] wd, input int d,
                           input logic [15:0] rhi, input logic [15:0] rlo,
                           input int exp_lat, input bit exp_err,
                           input logic [31:0] exp_rd, input string nm);
        logic [15:0] beats [$];
        logic [15:0] exp_b [$];
        logic [31:0] got_rd;
        logic        got_err;
        int w, ack_k, pulses, start_n, bad_start, rw_bad;
        wait_ready();
        sel   = 1'b1;
        rdwr  = rd;
        addr  = a;
        wdata = wd;
        exp_b = '{{8'h00, a[23:16]}, a[15:0]};
        if (!rd) begin
            exp_b.push_back(wd[31:16]);
            exp_b.push_back(wd[15:0]);
        end
        w = -1; ack_k = -1; pulses = 0; start_n = 0;
        bad_start = 0; rw_bad = 0; got_rd = '0; got_err = 1'b0;
        for (int k = 1; k <= BUDG; k++) begin
            @(negedge clk);
            addr  = 24'($urandom);
            wdata = $urandom;
            rdwr  = 1'($urandom);
            if (moe) beats.push_back(mad);
            if (mstart) begin
                start_n++;
                if (!(moe && beats.size() == 1)) bad_start++;
            end
            if (beats.size() > 0 && ack_k < 0 && mrdwr !== rd) rw_bad++;
            if (w < 0 && beats.size() > 0 && !moe) w = k;
            if (d >= 0 && w >= 0 && k == w + d) begin
                ack_in = 1'b1;
                ad_in  = rhi;
            end else if (d >= 0 && w >= 0 && k == w + d + 1) begin
                ack_in = 1'b0;
                ad_in  = rlo;
            end else begin
                ack_in = 1'b0;
                ad_in  = 16'($urandom);
            end
            if (cmd_ack) begin
                pulses++;
                if (ack_k < 0) begin
                    ack_k   = k;
                    got_err = cmd_err;
                    got_rd  = cmd_rdata;
                end
                sel = 1'b0;
            end
            if (ack_k >= 0 && k == ack_k + 1) break;
        end
        sel    = 1'b0;
        ack_in = 1'b0;
        if (ack_k < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: no o_cmd_ack within %0d cycles",
                     nm, BUDG);
            return;
        end
        chk({nm, "_nbeats"}, beats.size(), exp_b.size());
        for (int i = 0; i < exp_b.size() && i < beats.size(); i++)
            chk($sformatf("%s_beat%0d", nm, i), beats[i], exp_b[i]);
        chk({nm, "_starts"}, start_n, 1);
        chk({nm, "_start_pos"}, bad_start, 0);
        chk({nm, "_rdwr"}, rw_bad, 0);
        chk({nm, "_oe_off"}, w, rd ? 3 : 5);
        chk({nm, "_lat"}, ack_k, exp_lat);
        chk({nm, "_pulse"}, pulses, 1);
        chk({nm, "_err"}, got_err, exp_err);
        if (rd || exp_err) chk({nm, "_rdata"}, got_rd, exp_rd);
    endtask

    initial begin
        int d, r, ak, sk, acks;
        bit rd;
        logic [15:0] hi, lo;
        logic [23:0] a;
        logic [31:0] wd;

        tbl[0] = '{0, 24'h300010, 32'hCAFEF00D, 1, 16'h0, 16'h0,
                   8, 0, 32'h0};
        tbl[1] = '{1, 24'h200004, 32'h0, 0, 16'h1234, 16'h5678,
                   6, 0, 32'h12345678};
        tbl[2] = '{1, 24'h200004, 32'h0, -1, 16'h0, 16'h0,
                   260, 1, 32'h0};
        tbl[3] = '{0, 24'h123456, 32'h89ABCDEF, -1, 16'h0, 16'h0,
                   262, 1, 32'h0};
        tbl[4] = '{1, 24'hABCDEF, 32'h0, 255, 16'hBEEF, 16'h0001,
                   261, 0, 32'hBEEF0001};
        tbl[5] = '{1, 24'hABCDEF, 32'h0, 256, 16'hBEEF, 16'h0001,
                   260, 1, 32'h0};
        tbl[6] = '{0, 24'hF0000F, 32'h00FF00FF, 255, 16'h0, 16'h0,
                   262, 0, 32'h0};
        tbl[7] = '{0, 24'hF0000F, 32'h00FF00FF, 256, 16'h0, 16'h0,
                   262, 1, 32'h0};
        tbl[8] = '{1, 24'h0FFFFF, 32'h0, 5, 16'hFFFF, 16'h0000,
                   11, 0, 32'hFFFF0000};

        srst = 1'b1; sel = 1'b0; rdwr = 1'b0; addr = '0; wdata = '0;
        ad_in = '0; ack_in = 1'b0;
        repeat (3) @(negedge clk);
        chk_rst("reset");
        chk("reset_ready", ready, 0);

`ifdef MIB_MASTER_TBIT_EN
        sel = 1'b1; rdwr = 1'b1; addr = 24'h100000;
        srst = 1'b0;
        sk = -1;
        for (int k = 1; k <= TB + 4; k++) begin
            @(negedge clk);
            if (k <= TB) begin
                chk($sformatf("train_tbit%0d", k), tbit, k % 2);
                chk($sformatf("train_ready%0d", k), ready, 0);
            end
            if (k == TB + 1) begin
                chk("train_ready_up", ready, 1);
                chk("train_tbit_hold", tbit, 0);
            end
            if (mstart && sk < 0) sk = k;
        end
        chk("train_held_sel_start", sk, TB + 2);
        srst = 1'b1; sel = 1'b0;
        @(negedge clk);
        srst = 1'b0;
`else
        srst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", ready, 1);
        chk("tbit_idle", tbit, 0);
`endif

        for (int i = 0; i < 9; i++)
            run_txn(tbl[i].rd, tbl[i].a, tbl[i].wd, tbl[i].d, tbl[i].hi,
                    tbl[i].lo, tbl[i].lat, tbl[i].err, tbl[i].rdat,
                    $sformatf("vec%0d", i));

        // Reset during WR_HI aborts without an ack.
        wait_ready();
        sel = 1'b1; rdwr = 1'b0; addr = 24'h300010; wdata = 32'hCAFEF00D;
        repeat (3) @(negedge clk);
        chk("abort_wrhi_oe", moe, 1);
        chk("abort_wrhi_ad", mad, 16'hCAFE);
        srst = 1'b1; sel = 1'b0;
        @(negedge clk);
        chk("abort_oe", moe, 0);
        chk("abort_start", mstart, 0);
        chk("abort_ad", mad, 0);
        chk("abort_rdwr", mrdwr, 1);
        chk("abort_ack", cmd_ack, 0);
        srst = 1'b0;
        acks = 0;
        repeat (TB + 10) begin
            @(negedge clk);
            if (cmd_ack) acks++;
        end
        chk("abort_no_ack", acks, 0);
        run_txn(0, 24'h300010, 32'hCAFEF00D, 2, 16'h0, 16'h0,
                model_lat(0, 2), 0, 32'h0, "after_abort");

        // Early ack gives the minimum write; held sel restarts only after DONE.
        wait_ready();
        ack_in = 1'b1;
        sel = 1'b1; rdwr = 1'b0; addr = 24'h500000; wdata = 32'h1;
        ak = -1; sk = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (cmd_ack && ak < 0) ak = k;
            if (ak >= 0 && k > ak && mstart && sk < 0) sk = k;
        end
        chk("min_write_ack", ak, 6);
        chk("held_sel_restart", sk, 8);
        srst = 1'b1; sel = 1'b0; ack_in = 1'b0;
        @(negedge clk);
        srst = 1'b0;

        for (int i = 0; i < 30; i++) begin
            r  = $urandom_range(0, 9);
            d  = (r < 7) ? $urandom_range(0, 6) :
                 (r == 7) ? -1 : (r == 8) ? T - 1 : T;
            rd = 1'($urandom);
            a  = 24'($urandom);
            wd = $urandom;
            hi = 16'($urandom);
            lo = 16'($urandom);
            run_txn(rd, a, wd, d, hi, lo, model_lat(rd, d), model_err(d),
                    (rd && !model_err(d)) ? {hi, lo} : 32'h0,
                    $sformatf("rnd%0d", i));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
